// File: rtl/memory_read_ctrl.sv
// Egress read controller: walks a frame's linked list of packet-memory blocks,
// streams the payload as 1-byte beats and hands each consumed block back to the free list.
module memory_read_ctrl #(
    parameter int ADDR_W        = 14,
    parameter int BLOCK_BYTES   = 64,
    parameter int PAYLOAD_BYTES = 62,
    parameter int LEN_W         = 16,
    parameter int BLOCK_BITS    = 8 * BLOCK_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    input  logic [ADDR_W-1:0]     desc_start_idx_i,
    input  logic [LEN_W-1:0]      desc_len_i,
    input  logic                  mem_ready_i,
    output logic                  mem_re_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [BLOCK_BITS-1:0] mem_rdata_i,
    output logic                  fl_free_req_o,
    output logic [ADDR_W-1:0]     fl_free_block_idx_o,
    input  logic                  fl_free_gnt_i,
    output logic [7:0]            data_o,
    output logic                  data_valid_o,
    output logic                  data_begin_o,
    output logic                  data_end_o,
    input  logic                  data_ready_i,
    output logic                  err_o
);
    localparam int POS_W = $clog2(PAYLOAD_BYTES);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, STREAM} state_t;

    state_t                               state, state_nxt;
    logic [ADDR_W-1:0]                    idx, next_idx, free_idx;
    logic [LEN_W-1:0]                     rem;
    logic                                 first, eop, free_full, err;
    logic [PAYLOAD_BYTES-1:0][7:0]        payload;
    logic [POS_W-1:0]                     pos, pos_init;
    logic                                 desc_fire, beat, last_blk, rem_one, frame_end;
    logic                                 unused_rsvd;

    assign unused_rsvd = mem_rdata_i[0];

    // pos is the byte slot still to send; payload is right-justified so byte k sits at slot n-1-k
    assign pos_init  = (rem < LEN_W'(PAYLOAD_BYTES)) ? POS_W'(rem - LEN_W'(1))
                                                     : POS_W'(PAYLOAD_BYTES - 1);
    assign rem_one   = (rem == LEN_W'(1));
    assign last_blk  = (pos == '0);
    assign frame_end = last_blk && (rem_one || eop);
    assign beat      = data_valid_o && data_ready_i;
    assign desc_fire = desc_valid_i && desc_ready_o;

    always_comb begin
        state_nxt    = state;
        desc_ready_o = 1'b0;
        mem_re_o     = 1'b0;
        data_valid_o = 1'b0;
        case (state)
            IDLE: begin
                desc_ready_o = !free_full;
                if (desc_valid_i && !free_full) state_nxt = RD_REQ;
            end
            RD_REQ: begin
                mem_re_o = !free_full;
                if (mem_ready_i && !free_full) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid_i) state_nxt = STREAM;
            end
            STREAM: begin
                data_valid_o = 1'b1;
                if (data_ready_i && last_blk) state_nxt = (rem_one || eop) ? IDLE : RD_REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte outputs decode only from registers, so they hold steady across a sink stall
    assign data_o              = payload[pos];
    assign data_begin_o        = data_valid_o && first;
    assign data_end_o          = data_valid_o && frame_end;
    assign mem_addr_o          = idx;
    assign fl_free_req_o       = free_full;
    assign fl_free_block_idx_o = free_idx;
    assign err_o               = err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            next_idx  <= '0;
            free_idx  <= '0;
            rem       <= '0;
            first     <= 1'b0;
            eop       <= 1'b0;
            free_full <= 1'b0;
            err       <= 1'b0;
            payload   <= '0;
            pos       <= '0;
        end else begin
            state <= state_nxt;
            // mismatch: frame finished without eop, or eop seen with bytes still owed
            err   <= beat && last_blk && (rem_one != eop);
            if (desc_fire) begin
                idx   <= desc_start_idx_i;
                rem   <= (desc_len_i == '0) ? LEN_W'(1) : desc_len_i;
                first <= 1'b1;
            end
            if (state == RD_WAIT && mem_rvalid_i) begin
                payload  <= mem_rdata_i[BLOCK_BITS-1 -: 8*PAYLOAD_BYTES];
                next_idx <= mem_rdata_i[ADDR_W+1:2];
                eop      <= mem_rdata_i[1];
                pos      <= pos_init;
            end
            if (beat) begin
                rem   <= rem - LEN_W'(1);
                first <= 1'b0;
                if (!last_blk)       pos <= pos - POS_W'(1);
                else if (!frame_end) idx <= next_idx;
            end
            // never loaded while full: RD_REQ and IDLE both hold off until the grant
            if (beat && last_blk) begin
                free_full <= 1'b1;
                free_idx  <= idx;
            end else if (fl_free_gnt_i) begin
                free_full <= 1'b0;
            end
        end
    end
endmodule
